// File: rtl/serial_demux_deser_pkg.sv
// Shared helpers for the serial mux/demux family:
// select-width sizing and slot-order mapping.
package serial_demux_deser_pkg;

   function automatic int clog2_f(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic int slot_idx(
      input int sel,
      input int width,
      input bit msb_first
   );
      return msb_first ? width - 1 - sel : sel;
   endfunction

endpackage

// File: rtl/serial_demux_deser_if.sv
// Serial input side and parallel output side of the
// demux, bundled for the source and the deserializer.
interface serial_demux_deser_if
   import serial_demux_deser_pkg::*;
#(
   parameter int WIDTH = 8
);
   localparam int SEL_W = clog2_f(WIDTH);

   logic             din;
   logic             din_valid;
   logic             sync;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic [SEL_W-1:0] sel;
   logic             busy;

   modport master (
      output din, din_valid, sync,
      input  dout, dout_valid, sel, busy
   );

   modport slave (
      input  din, din_valid, sync,
      output dout, dout_valid, sel, busy
   );
endinterface

// File: rtl/serial_slot_counter.sv
// Modulo-WIDTH slot counter with enable, sync clear
// (sync with enable restarts at slot 1) and last flag.
module serial_slot_counter
   import serial_demux_deser_pkg::*;
#(
   parameter int WIDTH = 8,
   localparam int SEL_W = clog2_f(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_clr,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_last,
   output logic             o_busy
);
   localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

   logic [SEL_W-1:0] r_sel;
   logic             r_busy;
   logic [SEL_W-1:0] w_nxt;

   assign o_sel  = r_sel;
   assign o_busy = r_busy;
   assign o_last = (r_sel == LAST);

   always_comb begin
      w_nxt = r_sel;
      if (i_clr)
         w_nxt = i_en ? SEL_W'(1) : '0;
      else if (i_en)
         w_nxt = o_last ? '0 : r_sel + SEL_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel  <= '0;
         r_busy <= 1'b0;
      end else begin
         r_sel  <= w_nxt;
         r_busy <= (w_nxt != '0);
      end
   end
endmodule

// File: rtl/serial_demux_deser.sv
// Serial-to-parallel demux: steers each valid bit into
// the slot chosen by the counter, emits completed words.
module serial_demux_deser
   import serial_demux_deser_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_demux_deser_if.slave bus
);
   localparam int SEL_W = clog2_f(WIDTH);
   localparam bit MSBF  = (MSB_FIRST != 0);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] SLOT0 =
      ONE << slot_idx(0, WIDTH, MSBF);

   logic [SEL_W-1:0] w_sel;
   logic             w_last;
   logic             w_busy;
   logic [SEL_W-1:0] w_idx;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_merge;

   logic [WIDTH-1:0] r_shadow;
   logic [WIDTH-1:0] r_dout;
   logic             r_dv;

   serial_slot_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (bus.din_valid),
      .i_clr  (bus.sync),
      .o_sel  (w_sel),
      .o_last (w_last),
      .o_busy (w_busy)
   );

   assign w_idx  = SEL_W'(slot_idx(int'(w_sel), WIDTH, MSBF));
   assign w_mask = ONE << w_idx;
   // Merge the live bit so the last slot needs no extra cycle.
   assign w_merge = (r_shadow & ~w_mask)
                  | ({WIDTH{bus.din}} & w_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
         r_dout   <= '0;
         r_dv     <= 1'b0;
      end else begin
         r_dv <= 1'b0;
         if (bus.sync) begin
            r_shadow <= (bus.din_valid && bus.din)
                      ? SLOT0 : '0;
         end else if (bus.din_valid) begin
            if (w_last) begin
               r_dout   <= w_merge;
               r_dv     <= 1'b1;
               r_shadow <= '0;
            end else begin
               r_shadow <= w_merge;
            end
         end
      end
   end

   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_dv;
   assign bus.sel        = w_sel;
   assign bus.busy       = w_busy;
endmodule

// File: tb/tb_serial_demux_deser.sv
// Scoreboard bench: three demux configurations, expected
// words and pulse cycles queued by stimulus, popped by monitors.
module tb_serial_demux_deser;

   typedef struct {
      logic [63:0] d;
      int          c;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_fail;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   serial_demux_deser_if #(.WIDTH(8)) ia();
   serial_demux_deser_if #(.WIDTH(8)) ib();
   serial_demux_deser_if #(.WIDTH(5)) ic();

   serial_demux_deser #(.WIDTH(8), .MSB_FIRST(1)) ua (
      .clk(clk), .rst_n(rst_n), .bus(ia));
   serial_demux_deser #(.WIDTH(8), .MSB_FIRST(0)) ub (
      .clk(clk), .rst_n(rst_n), .bus(ib));
   serial_demux_deser #(.WIDTH(5), .MSB_FIRST(1)) uc (
      .clk(clk), .rst_n(rst_n), .bus(ic));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] req);
      n_chk = n_chk + 1;
      if (act !== req) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h",
                  nm, act, req);
      end
   endtask

   task automatic pop_chk(input string nm,
                          input logic [63:0] act,
                          input int which);
      exp_t e;
      int   sz;
      sz = (which == 0) ? qa.size()
         : (which == 1) ? qb.size() : qc.size();
      if (sz == 0) begin
         n_chk  = n_chk + 1;
         n_fail = n_fail + 1;
         $display("FAIL %s unexpected pulse: got %0h at cycle %0d, expected none",
                  nm, act, cyc);
      end else begin
         case (which)
            0: e = qa.pop_front();
            1: e = qb.pop_front();
            default: e = qc.pop_front();
         endcase
         chk({nm, " data"}, act, e.d);
         chk({nm, " cycle"}, 64'(cyc), 64'(e.c));
      end
   endtask

   always @(negedge clk)
      if (ia.dout_valid) pop_chk("A", 64'(ia.dout), 0);
   always @(negedge clk)
      if (ib.dout_valid) pop_chk("B", 64'(ib.dout), 1);
   always @(negedge clk) begin
      if (ic.dout_valid) pop_chk("C", 64'(ic.dout), 2);
      if (rst_n) chk("C sel range", 64'(ic.sel <= 3'd4), 64'd1);
   end

   task automatic drive(input int d, input bit v,
                        input bit b, input bit s);
      @(negedge clk);
      ia.din_valid = 0; ia.din = 0; ia.sync = 0;
      ib.din_valid = 0; ib.din = 0; ib.sync = 0;
      ic.din_valid = 0; ic.din = 0; ic.sync = 0;
      case (d)
         0: begin ia.din_valid = v; ia.din = b; ia.sync = s; end
         1: begin ib.din_valid = v; ib.din = b; ib.sync = s; end
         2: begin ic.din_valid = v; ic.din = b; ic.sync = s; end
         default: ;
      endcase
   endtask

   task automatic push(input int d, input logic [63:0] w);
      exp_t e;
      e.d = w;
      e.c = cyc + 1;
      case (d)
         0: qa.push_back(e);
         1: qb.push_back(e);
         default: qc.push_back(e);
      endcase
   endtask

   task automatic sendseq(input int d, input logic [63:0] s,
                          input int n);
      for (int i = 0; i < n; i++)
         drive(d, 1'b1, s[n-1-i], 1'b0);
   endtask

   logic [7:0] v5a;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      ia.din_valid = 0; ia.din = 0; ia.sync = 0;
      ib.din_valid = 0; ib.din = 0; ib.sync = 0;
      ic.din_valid = 0; ic.din = 0; ic.sync = 0;
      repeat (2) @(negedge clk);
      chk("rst A sel", 64'(ia.sel), 0);
      chk("rst A busy", 64'(ia.busy), 0);
      chk("rst A dout", 64'(ia.dout), 0);
      chk("rst A dv", 64'(ia.dout_valid), 0);
      chk("rst B dout", 64'(ib.dout), 0);
      chk("rst C sel", 64'(ic.sel), 0);
      rst_n = 1'b1;

      sendseq(0, 64'b11000000, 8);
      push(0, 64'hC0);
      drive(0, 0, 0, 0);
      chk("A C0 sel", 64'(ia.sel), 0);
      chk("A C0 busy", 64'(ia.busy), 0);
      chk("A C0 dout", 64'(ia.dout), 64'hC0);

      v5a = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         drive(0, 1'b1, v5a[7-i], 1'b0);
         if (i == 7) push(0, 64'h5A);
         for (int g = 0; g < 3; g++) begin
            drive(0, 0, 0, 0);
            if (g == 0) begin
               chk("A gap sel", 64'(ia.sel), 64'((i + 1) % 8));
               chk("A gap busy", 64'(ia.busy), 64'(i != 7));
               chk("A gap dout", 64'(ia.dout),
                   (i == 7) ? 64'h5A : 64'hC0);
            end
         end
      end

      sendseq(0, 64'b11111, 5);
      drive(0, 1, 1, 1);
      drive(0, 0, 0, 0);
      chk("A sync mid sel", 64'(ia.sel), 1);
      sendseq(0, 64'b0000000, 7);
      push(0, 64'h80);
      drive(0, 0, 0, 0);
      chk("A sync mid dout", 64'(ia.dout), 64'h80);

      sendseq(0, 64'b0000000, 7);
      drive(0, 1, 1, 1);
      drive(0, 0, 0, 0);
      chk("A sync last sel", 64'(ia.sel), 1);
      chk("A sync last busy", 64'(ia.busy), 1);
      chk("A sync last dout", 64'(ia.dout), 64'h80);
      sendseq(0, 64'b0000001, 7);
      push(0, 64'h81);
      drive(0, 0, 0, 0);
      chk("A 81 dout", 64'(ia.dout), 64'h81);

      sendseq(1, 64'b11000000, 8);
      push(1, 64'h03);
      sendseq(1, 64'b10100101, 8);
      push(1, 64'hA5);
      drive(1, 0, 0, 0);
      chk("B A5 dout", 64'(ib.dout), 64'hA5);
      chk("B A5 sel", 64'(ib.sel), 0);

      sendseq(2, 64'b10011, 5);
      push(2, 64'h13);
      sendseq(2, 64'b10011, 5);
      push(2, 64'h13);
      drive(2, 0, 0, 0);
      chk("C dout", 64'(ic.dout), 64'h13);
      chk("C sel", 64'(ic.sel), 0);

      sendseq(0, 64'b1111, 4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("A arst sel", 64'(ia.sel), 0);
      chk("A arst busy", 64'(ia.busy), 0);
      chk("A arst dout", 64'(ia.dout), 0);
      chk("A arst dv", 64'(ia.dout_valid), 0);
      rst_n = 1'b1;
      sendseq(0, 64'hFF, 8);
      push(0, 64'hFF);
      drive(0, 0, 0, 0);
      chk("A FF dout", 64'(ia.dout), 64'hFF);

      repeat (4) drive(3, 0, 0, 0);
      chk("A queue empty", 64'(qa.size()), 0);
      chk("B queue empty", 64'(qb.size()), 0);
      chk("C queue empty", 64'(qc.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
